// File: rtl/usb_bulk_router_pkg.sv
// Shared USB PID field codes and small helpers for the bulk-endpoint router.
// Only the codes the router decodes are defined; SOF/SETUP, NYET and DATA2/MDATA fall through.
package usb_bulk_router_pkg;

    localparam logic [1:0] TokOut   = 2'b00;
    localparam logic [1:0] TokIn    = 2'b10;

    localparam logic [1:0] HskAck   = 2'b00;
    localparam logic [1:0] HskNak   = 2'b10;
    localparam logic [1:0] HskStall = 2'b11;

    localparam logic [1:0] PidData0 = 2'b00;
    localparam logic [1:0] PidData1 = 2'b10;

    function automatic logic [1:0] data_pid(input logic tog);
        return tog ? PidData1 : PidData0;
    endfunction

endpackage

// File: rtl/usb_ep_tx_mux.sv
// NUM_EPS:1 AXI4-Stream mux for IN payloads; the select is registered when a transfer starts
// and tready is only returned to the selected endpoint while the mux is enabled.
module usb_ep_tx_mux #(
    parameter int unsigned NUM_EPS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sel_load_i,
    input  logic [3:0]             sel_i,
    input  logic                   en_i,
    input  logic [NUM_EPS-1:0]     s_tvalid_i,
    input  logic [NUM_EPS-1:0]     s_tlast_i,
    input  logic [8*NUM_EPS-1:0]   s_tdata_i,
    output logic [NUM_EPS-1:0]     s_tready_o,
    output logic                   m_tvalid_o,
    output logic                   m_tlast_o,
    output logic [7:0]             m_tdata_o,
    input  logic                   m_tready_i
);

    logic [3:0] sel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q <= '0;
        end else if (sel_load_i) begin
            sel_q <= sel_i;
        end
    end

    always_comb begin
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tdata_o  = '0;
        s_tready_o = '0;
        for (int i = 0; i < NUM_EPS; i++) begin
            if (en_i && sel_q == 4'(i)) begin
                m_tvalid_o    = s_tvalid_i[i];
                m_tlast_o     = s_tlast_i[i];
                m_tdata_o     = s_tdata_i[8*i +: 8];
                s_tready_o[i] = m_tready_i;
            end
        end
    end

endmodule

// File: rtl/usb_bulk_router.sv
// Bulk-endpoint transaction engine: decodes OUT/IN tokens for EP1..NUM_EPS, keeps per-direction
// DATA0/1 toggles, routes payload streams and issues or consumes the handshake.
module usb_bulk_router
    import usb_bulk_router_pkg::*;
#(
    parameter int unsigned        NUM_EPS     = 2,
    parameter logic [NUM_EPS-1:0] EP_IN_MASK  = 2'b11,
    parameter logic [NUM_EPS-1:0] EP_OUT_MASK = 2'b01,
    parameter int unsigned        TIMEOUT     = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [6:0]             usb_addr_i,
    input  logic                   tok_recv_i,
    input  logic [1:0]             tok_type_i,
    input  logic [6:0]             tok_addr_i,
    input  logic [3:0]             tok_endp_i,
    input  logic                   usb_recv_i,
    input  logic [1:0]             usb_type_i,
    input  logic                   crc_err_i,
    input  logic                   rx_tvalid_i,
    output logic                   rx_tready_o,
    input  logic                   rx_tlast_i,
    input  logic [7:0]             rx_tdata_i,
    input  logic                   hsk_recv_i,
    input  logic [1:0]             hsk_type_i,
    output logic                   hsk_send_o,
    output logic [1:0]             hsk_type_o,
    input  logic                   hsk_sent_i,
    output logic                   trn_send_o,
    output logic [1:0]             trn_type_o,
    input  logic                   trn_done_i,
    output logic                   tx_tvalid_o,
    input  logic                   tx_tready_i,
    output logic                   tx_tlast_o,
    output logic [7:0]             tx_tdata_o,
    output logic [NUM_EPS-1:0]     ep_rx_tvalid_o,
    input  logic [NUM_EPS-1:0]     ep_rx_tready_i,
    output logic                   ep_rx_tlast_o,
    output logic [7:0]             ep_rx_tdata_o,
    input  logic [NUM_EPS-1:0]     ep_rx_ready_i,
    output logic [NUM_EPS-1:0]     ep_rx_commit_o,
    output logic [NUM_EPS-1:0]     ep_rx_abort_o,
    input  logic [NUM_EPS-1:0]     ep_tx_ready_i,
    input  logic [NUM_EPS-1:0]     ep_tx_tvalid_i,
    input  logic [NUM_EPS-1:0]     ep_tx_tlast_i,
    input  logic [8*NUM_EPS-1:0]   ep_tx_tdata_i,
    output logic [NUM_EPS-1:0]     ep_tx_tready_o,
    output logic [NUM_EPS-1:0]     ep_tx_ack_o,
    input  logic [NUM_EPS-1:0]     ep_halt_i,
    input  logic [NUM_EPS-1:0]     ep_clear_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StRxData, StRxHsk, StTxData, StTxWait, StTxHsk, StHskDone
    } state_e;

    function automatic logic pick(input logic [NUM_EPS-1:0] v, input logic [3:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_EPS; i++) begin
            if (idx == 4'(i)) r = v[i];
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         ep_q, ep_d;
    logic [NUM_EPS-1:0] tog_out_q, tog_out_d, tog_in_q, tog_in_d;
    logic               got_pid_q, got_pid_d, halt_q, halt_d, rdy_q, rdy_d, match_q, match_d;
    logic               crc_q, crc_d, commit_pend_q, commit_pend_d;
    logic [1:0]         hsk_type_q, hsk_type_d, trn_type_q, trn_type_d;
    logic               trn_send_q, trn_send_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_EPS-1:0] commit_q, commit_d, abort_q, abort_d, ack_q, ack_d;

    logic               addr_ok, tok_hit_in, tok_hit_out;
    logic [3:0]         tok_idx;
    logic [NUM_EPS-1:0] ep_oh;
    logic               fwd, in_rx, timeout_hit, flip_out, flip_in, sel_load, tx_en, last_beat;

    always_comb begin
        tok_hit_in  = 1'b0;
        tok_hit_out = 1'b0;
        tok_idx     = '0;
        for (int i = 0; i < NUM_EPS; i++) begin
            if (tok_endp_i == 4'(i + 1)) begin
                tok_idx     = 4'(i);
                tok_hit_in  = EP_IN_MASK[i];
                tok_hit_out = EP_OUT_MASK[i];
            end
        end
        for (int i = 0; i < NUM_EPS; i++) begin
            ep_oh[i] = (ep_q == 4'(i));
        end
    end

    assign addr_ok     = (tok_addr_i == usb_addr_i);
    assign fwd         = got_pid_q & ~halt_q & rdy_q & match_q;
    assign in_rx       = (state_q == StRxData);
    assign timeout_hit = (timer_q == TW'(TIMEOUT));
    assign last_beat   = in_rx & rx_tvalid_i & rx_tready_o & rx_tlast_i;

    always_comb begin
        state_d       = state_q;
        ep_d          = ep_q;
        got_pid_d     = got_pid_q;
        halt_d        = halt_q;
        rdy_d         = rdy_q;
        match_d       = match_q;
        crc_d         = crc_q;
        commit_pend_d = commit_pend_q;
        hsk_type_d    = hsk_type_q;
        trn_type_d    = trn_type_q;
        trn_send_d    = 1'b0;
        timer_d       = (state_q == StRxData || state_q == StTxWait) ? timer_q + 1'b1 : timer_q;
        commit_d      = '0;
        abort_d       = '0;
        ack_d         = '0;
        flip_out      = 1'b0;
        flip_in       = 1'b0;
        sel_load      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tok_recv_i && addr_ok && tok_type_i == TokOut && tok_hit_out) begin
                    state_d       = StRxData;
                    ep_d          = tok_idx;
                    got_pid_d     = 1'b0;
                    halt_d        = 1'b0;
                    rdy_d         = 1'b0;
                    match_d       = 1'b0;
                    crc_d         = 1'b0;
                    commit_pend_d = 1'b0;
                    timer_d       = '0;
                end else if (tok_recv_i && addr_ok && tok_type_i == TokIn && tok_hit_in) begin
                    ep_d = tok_idx;
                    if (pick(ep_halt_i, tok_idx)) begin
                        hsk_type_d = HskStall;
                        state_d    = StTxHsk;
                    end else if (!pick(ep_tx_ready_i, tok_idx)) begin
                        hsk_type_d = HskNak;
                        state_d    = StTxHsk;
                    end else begin
                        state_d    = StTxData;
                        trn_send_d = 1'b1;
                        trn_type_d = data_pid(pick(tog_in_q, tok_idx));
                        sel_load   = 1'b1;
                    end
                end
            end
            StRxData: begin
                // Endpoint status is frozen at the DATAx PID so the handshake matches what was routed.
                if (usb_recv_i && !got_pid_q) begin
                    got_pid_d = 1'b1;
                    halt_d    = pick(ep_halt_i, ep_q);
                    rdy_d     = pick(ep_rx_ready_i, ep_q);
                    match_d   = (usb_type_i == data_pid(pick(tog_out_q, ep_q)));
                end
                if (crc_err_i) crc_d = 1'b1;
                if (last_beat) begin
                    if (crc_q || crc_err_i) begin
                        abort_d = fwd ? ep_oh : '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StRxHsk;
                        if (halt_q) begin
                            hsk_type_d = HskStall;
                        end else if (!rdy_q) begin
                            hsk_type_d = HskNak;
                        end else begin
                            hsk_type_d    = HskAck;
                            commit_pend_d = fwd;
                        end
                    end
                end else if (timeout_hit) begin
                    abort_d = fwd ? ep_oh : '0;
                    state_d = StIdle;
                end
            end
            StRxHsk, StTxHsk: state_d = StHskDone;
            StHskDone: begin
                if (hsk_sent_i) begin
                    state_d       = StIdle;
                    commit_pend_d = 1'b0;
                    if (commit_pend_q) begin
                        commit_d = ep_oh;
                        flip_out = 1'b1;
                    end
                end
            end
            StTxData: begin
                if (trn_done_i) begin
                    state_d = StTxWait;
                    timer_d = '0;
                end
            end
            StTxWait: begin
                if (hsk_recv_i) begin
                    state_d = StIdle;
                    if (hsk_type_i == HskAck) begin
                        ack_d   = ep_oh;
                        flip_in = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        tog_out_d = (flip_out ? tog_out_q ^ ep_oh : tog_out_q) & ~ep_clear_i;
        tog_in_d  = (flip_in ? tog_in_q ^ ep_oh : tog_in_q) & ~ep_clear_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            ep_q          <= '0;
            tog_out_q     <= '0;
            tog_in_q      <= '0;
            got_pid_q     <= 1'b0;
            halt_q        <= 1'b0;
            rdy_q         <= 1'b0;
            match_q       <= 1'b0;
            crc_q         <= 1'b0;
            commit_pend_q <= 1'b0;
            hsk_type_q    <= '0;
            trn_type_q    <= '0;
            trn_send_q    <= 1'b0;
            timer_q       <= '0;
            commit_q      <= '0;
            abort_q       <= '0;
            ack_q         <= '0;
        end else begin
            state_q       <= state_d;
            ep_q          <= ep_d;
            tog_out_q     <= tog_out_d;
            tog_in_q      <= tog_in_d;
            got_pid_q     <= got_pid_d;
            halt_q        <= halt_d;
            rdy_q         <= rdy_d;
            match_q       <= match_d;
            crc_q         <= crc_d;
            commit_pend_q <= commit_pend_d;
            hsk_type_q    <= hsk_type_d;
            trn_type_q    <= trn_type_d;
            trn_send_q    <= trn_send_d;
            timer_q       <= timer_d;
            commit_q      <= commit_d;
            abort_q       <= abort_d;
            ack_q         <= ack_d;
        end
    end

    // Non-forwarded OUT data is still drained so the decoder never stalls.
    assign rx_tready_o    = in_rx ? (fwd ? pick(ep_rx_tready_i, ep_q) : 1'b1) : 1'b0;
    assign ep_rx_tvalid_o = (in_rx && fwd && rx_tvalid_i) ? ep_oh : '0;
    assign ep_rx_tlast_o  = in_rx & rx_tlast_i;
    assign ep_rx_tdata_o  = in_rx ? rx_tdata_i : 8'h00;
    assign hsk_send_o     = (state_q == StRxHsk) || (state_q == StTxHsk);
    assign hsk_type_o     = hsk_type_q;
    assign trn_send_o     = trn_send_q;
    assign trn_type_o     = trn_type_q;
    assign ep_rx_commit_o = commit_q;
    assign ep_rx_abort_o  = abort_q;
    assign ep_tx_ack_o    = ack_q;
    assign tx_en          = (state_q == StTxData);

    usb_ep_tx_mux #(
        .NUM_EPS (NUM_EPS)
    ) u_tx_mux (
        .clock      (clock),
        .reset      (reset),
        .sel_load_i (sel_load),
        .sel_i      (tok_idx),
        .en_i       (tx_en),
        .s_tvalid_i (ep_tx_tvalid_i),
        .s_tlast_i  (ep_tx_tlast_i),
        .s_tdata_i  (ep_tx_tdata_i),
        .s_tready_o (ep_tx_tready_o),
        .m_tvalid_o (tx_tvalid_o),
        .m_tlast_o  (tx_tlast_o),
        .m_tdata_o  (tx_tdata_o),
        .m_tready_i (tx_tready_i)
    );

endmodule

// File: tb/tb_usb_bulk_router.sv
// Scoreboard bench for usb_bulk_router: expected handshakes, data beats and pulses are queued
// as stimulus is driven and matched by negedge monitors as the DUT produces them.
module tb_usb_bulk_router;
    import usb_bulk_router_pkg::*;

    localparam int unsigned TO = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  usb_addr_i;
    logic        tok_recv_i;
    logic [1:0]  tok_type_i;
    logic [6:0]  tok_addr_i;
    logic [3:0]  tok_endp_i;
    logic        usb_recv_i;
    logic [1:0]  usb_type_i;
    logic        crc_err_i;
    logic        rx_tvalid_i, rx_tready_o, rx_tlast_i;
    logic [7:0]  rx_tdata_i;
    logic        hsk_recv_i;
    logic [1:0]  hsk_type_i;
    logic        hsk_send_o, hsk_sent_i;
    logic [1:0]  hsk_type_o;
    logic        trn_send_o, trn_done_i;
    logic [1:0]  trn_type_o;
    logic        tx_tvalid_o, tx_tready_i, tx_tlast_o;
    logic [7:0]  tx_tdata_o;
    logic [1:0]  ep_rx_tvalid_o, ep_rx_tready_i, ep_rx_ready_i, ep_rx_commit_o, ep_rx_abort_o;
    logic        ep_rx_tlast_o;
    logic [7:0]  ep_rx_tdata_o;
    logic [1:0]  ep_tx_ready_i, ep_tx_tvalid_i, ep_tx_tlast_i, ep_tx_tready_o, ep_tx_ack_o;
    logic [15:0] ep_tx_tdata_i;
    logic [1:0]  ep_halt_i, ep_clear_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  hsk_exp_q[$];
    logic [1:0]  trn_exp_q[$];
    logic [10:0] rx_exp_q[$];
    logic [8:0]  tx_exp_q[$];
    logic [5:0]  pulse_exp_q[$];

    always #5 clock = ~clock;

    usb_bulk_router #(
        .NUM_EPS     (2),
        .EP_IN_MASK  (2'b11),
        .EP_OUT_MASK (2'b01),
        .TIMEOUT     (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .usb_addr_i     (usb_addr_i),
        .tok_recv_i     (tok_recv_i),
        .tok_type_i     (tok_type_i),
        .tok_addr_i     (tok_addr_i),
        .tok_endp_i     (tok_endp_i),
        .usb_recv_i     (usb_recv_i),
        .usb_type_i     (usb_type_i),
        .crc_err_i      (crc_err_i),
        .rx_tvalid_i    (rx_tvalid_i),
        .rx_tready_o    (rx_tready_o),
        .rx_tlast_i     (rx_tlast_i),
        .rx_tdata_i     (rx_tdata_i),
        .hsk_recv_i     (hsk_recv_i),
        .hsk_type_i     (hsk_type_i),
        .hsk_send_o     (hsk_send_o),
        .hsk_type_o     (hsk_type_o),
        .hsk_sent_i     (hsk_sent_i),
        .trn_send_o     (trn_send_o),
        .trn_type_o     (trn_type_o),
        .trn_done_i     (trn_done_i),
        .tx_tvalid_o    (tx_tvalid_o),
        .tx_tready_i    (tx_tready_i),
        .tx_tlast_o     (tx_tlast_o),
        .tx_tdata_o     (tx_tdata_o),
        .ep_rx_tvalid_o (ep_rx_tvalid_o),
        .ep_rx_tready_i (ep_rx_tready_i),
        .ep_rx_tlast_o  (ep_rx_tlast_o),
        .ep_rx_tdata_o  (ep_rx_tdata_o),
        .ep_rx_ready_i  (ep_rx_ready_i),
        .ep_rx_commit_o (ep_rx_commit_o),
        .ep_rx_abort_o  (ep_rx_abort_o),
        .ep_tx_ready_i  (ep_tx_ready_i),
        .ep_tx_tvalid_i (ep_tx_tvalid_i),
        .ep_tx_tlast_i  (ep_tx_tlast_i),
        .ep_tx_tdata_i  (ep_tx_tdata_i),
        .ep_tx_tready_o (ep_tx_tready_o),
        .ep_tx_ack_o    (ep_tx_ack_o),
        .ep_halt_i      (ep_halt_i),
        .ep_clear_i     (ep_clear_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors: every strobe, beat or pulse must match the head of its queue.
    always @(negedge clock) begin
        if (hsk_send_o || trn_send_o) check("send_excl", 32'(hsk_send_o & trn_send_o), 0);
        if (hsk_send_o) begin
            if (hsk_exp_q.size() == 0) check("hsk_unexpected", 32'(hsk_type_o) + 1, 0);
            else check("hsk_type", 32'(hsk_type_o), 32'(hsk_exp_q.pop_front()));
        end
        if (trn_send_o) begin
            if (trn_exp_q.size() == 0) check("trn_unexpected", 32'(trn_type_o) + 1, 0);
            else check("trn_type", 32'(trn_type_o), 32'(trn_exp_q.pop_front()));
        end
        if (|(ep_rx_tvalid_o & ep_rx_tready_i)) begin
            if (rx_exp_q.size() == 0) check("rx_unexpected", 32'(ep_rx_tdata_o) + 1, 0);
            else check("rx_beat", 32'({ep_rx_tvalid_o, ep_rx_tlast_o, ep_rx_tdata_o}),
                       32'(rx_exp_q.pop_front()));
        end
        if (tx_tvalid_o && tx_tready_i) begin
            if (tx_exp_q.size() == 0) check("tx_unexpected", 32'(tx_tdata_o) + 1, 0);
            else check("tx_beat", 32'({tx_tlast_o, tx_tdata_o}), 32'(tx_exp_q.pop_front()));
        end
        if (|{ep_rx_commit_o, ep_rx_abort_o, ep_tx_ack_o}) begin
            if (pulse_exp_q.size() == 0)
                check("pulse_unexpected", 32'({ep_rx_commit_o, ep_rx_abort_o, ep_tx_ack_o}), 0);
            else check("pulse", 32'({ep_rx_commit_o, ep_rx_abort_o, ep_tx_ack_o}),
                       32'(pulse_exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_token(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e);
        tok_type_i = t;
        tok_addr_i = a;
        tok_endp_i = e;
        tok_recv_i = 1'b1;
        @(posedge clock);
        #1;
        tok_recv_i = 1'b0;
    endtask

    task automatic finish_hsk();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (hsk_send_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("hsk_wait", 0, 1);
        @(posedge clock);
        #1;
        hsk_sent_i = 1'b1;
        @(posedge clock);
        #1;
        hsk_sent_i = 1'b0;
    endtask

    task automatic do_out(input logic [1:0] pid, input int n, input logic [7:0] base,
                          input logic crc);
        logic ok;
        send_token(TokOut, 7'd3, 4'd1);
        usb_type_i = pid;
        usb_recv_i = 1'b1;
        @(posedge clock);
        #1;
        usb_recv_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = base + 8'(i);
            rx_tlast_i  = (i == n - 1);
            crc_err_i   = crc && (i == n - 1);
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clock);
                if (rx_tready_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("rx_tready_wait", 0, 1);
            @(posedge clock);
            #1;
        end
        rx_tvalid_i = 1'b0;
        rx_tlast_i  = 1'b0;
        crc_err_i   = 1'b0;
    endtask

    task automatic do_in(input logic [1:0] exp_pid, input int n, input logic reply,
                         input logic [1:0] reply_type);
        logic ok;
        trn_exp_q.push_back(exp_pid);
        for (int i = 0; i < n; i++) tx_exp_q.push_back({(i == n - 1), 8'hA0 + 8'(i)});
        if (reply && reply_type == HskAck) pulse_exp_q.push_back(6'b00_00_10);
        send_token(TokIn, 7'd3, 4'd2);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (trn_send_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("trn_send_wait", 0, 1);
            idle(TO + 20);
            return;
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < n; i++) begin
            ep_tx_tvalid_i[1]    = 1'b1;
            ep_tx_tlast_i[1]     = (i == n - 1);
            ep_tx_tdata_i[15:8]  = 8'hA0 + 8'(i);
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (ep_tx_tready_o[1]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("tx_tready_wait", 0, 1);
            @(posedge clock);
            #1;
        end
        ep_tx_tvalid_i = '0;
        ep_tx_tlast_i  = '0;
        trn_done_i = 1'b1;
        @(posedge clock);
        #1;
        trn_done_i = 1'b0;
        if (reply) begin
            idle(2);
            hsk_type_i = reply_type;
            hsk_recv_i = 1'b1;
            @(posedge clock);
            #1;
            hsk_recv_i = 1'b0;
            idle(3);
        end else begin
            idle(TO + 20);
        end
    endtask

    logic [12:0] bad_tok [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        usb_addr_i = 7'd3;
        tok_recv_i = 0; tok_type_i = 0; tok_addr_i = 0; tok_endp_i = 0;
        usb_recv_i = 0; usb_type_i = 0; crc_err_i = 0;
        rx_tvalid_i = 0; rx_tlast_i = 0; rx_tdata_i = 0;
        hsk_recv_i = 0; hsk_type_i = 0; hsk_sent_i = 0; trn_done_i = 0;
        tx_tready_i = 1'b1;
        ep_rx_tready_i = 2'b11; ep_rx_ready_i = 2'b01;
        ep_tx_ready_i = 2'b10; ep_tx_tvalid_i = 0; ep_tx_tlast_i = 0; ep_tx_tdata_i = 0;
        ep_halt_i = 0; ep_clear_i = 0;
        idle(3);

        check("rst_rx_tready", 32'(rx_tready_o), 0);
        check("rst_hsk_send", 32'({hsk_send_o, hsk_type_o}), 0);
        check("rst_trn_send", 32'({trn_send_o, trn_type_o}), 0);
        check("rst_tx", 32'({tx_tvalid_o, ep_tx_tready_o}), 0);
        check("rst_pulses", 32'({ep_rx_commit_o, ep_rx_abort_o, ep_tx_ack_o, ep_rx_tvalid_o}), 0);
        reset = 1'b0;
        idle(2);

        // OUT EP1 DATA0 accepted
        for (int i = 0; i < 8; i++) rx_exp_q.push_back({2'b01, (i == 7), 8'h10 + 8'(i)});
        hsk_exp_q.push_back(HskAck);
        pulse_exp_q.push_back(6'b01_00_00);
        do_out(PidData0, 8, 8'h10, 1'b0);
        finish_hsk();
        idle(4);

        // Repeated DATA0: ACKed, sunk, no commit
        hsk_exp_q.push_back(HskAck);
        do_out(PidData0, 5, 8'h30, 1'b0);
        finish_hsk();
        idle(4);

        // DATA1 is now the expected toggle
        for (int i = 0; i < 3; i++) rx_exp_q.push_back({2'b01, (i == 2), 8'h50 + 8'(i)});
        hsk_exp_q.push_back(HskAck);
        pulse_exp_q.push_back(6'b01_00_00);
        do_out(PidData1, 3, 8'h50, 1'b0);
        finish_hsk();
        idle(4);

        // No room -> NAK
        ep_rx_ready_i = 2'b00;
        hsk_exp_q.push_back(HskNak);
        do_out(PidData0, 4, 8'h60, 1'b0);
        finish_hsk();
        idle(4);
        ep_rx_ready_i = 2'b01;

        // CRC error on last byte -> abort, no handshake
        for (int i = 0; i < 4; i++) rx_exp_q.push_back({2'b01, (i == 3), 8'h70 + 8'(i)});
        pulse_exp_q.push_back(6'b00_01_00);
        do_out(PidData0, 4, 8'h70, 1'b1);
        idle(20);

        // IN EP2: ACK, timeout retry, NAK retry
        do_in(PidData0, 4, 1'b1, HskAck);
        do_in(PidData1, 4, 1'b0, HskAck);
        do_in(PidData1, 4, 1'b1, HskAck);
        do_in(PidData0, 2, 1'b1, HskNak);
        do_in(PidData0, 2, 1'b1, HskAck);

        // Halted -> STALL; clear resets the IN toggle (currently DATA1)
        ep_halt_i = 2'b10;
        hsk_exp_q.push_back(HskStall);
        send_token(TokIn, 7'd3, 4'd2);
        finish_hsk();
        idle(3);
        ep_halt_i  = 2'b00;
        ep_clear_i = 2'b10;
        idle(1);
        ep_clear_i = 2'b00;
        do_in(PidData0, 3, 1'b1, HskAck);

        // Nothing queued -> NAK
        ep_tx_ready_i = 2'b00;
        hsk_exp_q.push_back(HskNak);
        send_token(TokIn, 7'd3, 4'd2);
        finish_hsk();
        idle(3);
        ep_tx_ready_i = 2'b10;

        // Ignored tokens: wrong address, EP0, out of range, unsupported direction, SETUP
        bad_tok = '{{TokOut, 7'd5, 4'd1}, {TokOut, 7'd3, 4'd0}, {TokOut, 7'd3, 4'd3},
                    {TokOut, 7'd3, 4'd2}, {TokIn, 7'd5, 4'd2}, {TokIn, 7'd3, 4'd0},
                    {TokIn, 7'd3, 4'd3}, {2'b11, 7'd3, 4'd1}, {2'b01, 7'd3, 4'd1}};
        for (int i = 0; i < 9; i++) begin
            send_token(bad_tok[i][12:11], bad_tok[i][10:4], bad_tok[i][3:0]);
            idle(3);
            check("bad_tok_rx_tready", 32'(rx_tready_o), 0);
        end

        // OUT toggle is still DATA0 after the aborted packet
        for (int i = 0; i < 2; i++) rx_exp_q.push_back({2'b01, (i == 1), 8'h90 + 8'(i)});
        hsk_exp_q.push_back(HskAck);
        pulse_exp_q.push_back(6'b01_00_00);
        do_out(PidData0, 2, 8'h90, 1'b0);
        finish_hsk();
        idle(10);

        check("left_hsk", hsk_exp_q.size(), 0);
        check("left_trn", trn_exp_q.size(), 0);
        check("left_rx", rx_exp_q.size(), 0);
        check("left_tx", tx_exp_q.size(), 0);
        check("left_pulse", pulse_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
